// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 register file (Status, Cause, EPC, BadVAddr, Count, Compare)
// and precise-exception arbiter for the MEM2 commit point.
module cp0_exception_unit #(
    parameter bit TIMER_IRQ_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [5:0]  int_i,
    input  logic [31:0] pc_i,
    input  logic        delay_slot_i,
    input  logic [7:0]  exc_flags_i,
    input  logic [31:0] bad_addr_i,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic [3:0]  exception_type,
    output logic [31:0] cp0_epc,
    output logic        timer_int_o
);

    typedef enum logic [3:0] {
        EXC_NULL = 4'd0,
        EXC_INT  = 4'd1,
        EXC_ADEL = 4'd2,
        EXC_ADES = 4'd3,
        EXC_SYS  = 4'd4,
        EXC_BP   = 4'd5,
        EXC_RI   = 4'd6,
        EXC_OV   = 4'd7,
        EXC_ERET = 4'd8
    } exc_e;

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        count_tog;

    exc_e        exc;
    logic [4:0]  exc_code;
    logic        bad_from_pc;
    logic        bad_from_addr;
    logic        int_pending;
    logic        take_exc;
    logic        do_eret;
    logic        do_mtc0;

    assign int_pending = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));

    // Priority arbitration of the committing instruction's exception sources
    always_comb begin
        exc           = EXC_NULL;
        exc_code      = 5'd0;
        bad_from_pc   = 1'b0;
        bad_from_addr = 1'b0;
        if (!stall) begin
            if (int_pending && (pc_i != '0)) begin
                exc      = EXC_INT;
                exc_code = 5'd0;
            end else if (exc_flags_i[0]) begin
                exc         = EXC_ADEL;
                exc_code    = 5'd4;
                bad_from_pc = 1'b1;
            end else if (exc_flags_i[1]) begin
                exc      = EXC_RI;
                exc_code = 5'd10;
            end else if (exc_flags_i[2]) begin
                exc      = EXC_OV;
                exc_code = 5'd12;
            end else if (exc_flags_i[3]) begin
                exc      = EXC_SYS;
                exc_code = 5'd8;
            end else if (exc_flags_i[4]) begin
                exc      = EXC_BP;
                exc_code = 5'd9;
            end else if (exc_flags_i[5]) begin
                exc = EXC_ERET;
            end else if (exc_flags_i[6]) begin
                exc           = EXC_ADEL;
                exc_code      = 5'd4;
                bad_from_addr = 1'b1;
            end else if (exc_flags_i[7]) begin
                exc           = EXC_ADES;
                exc_code      = 5'd5;
                bad_from_addr = 1'b1;
            end
        end
    end

    assign exception_type = exc;
    assign take_exc       = (exc != EXC_NULL) && (exc != EXC_ERET);
    assign do_eret        = (exc == EXC_ERET);
    assign do_mtc0        = cp0_we & ~stall & (exc == EXC_NULL);

    // CP0 register state: free-running timer, interrupt sampling, exception entry/return, MTC0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status    <= STATUS_RESET;
            cause     <= '0;
            epc       <= '0;
            badvaddr  <= '0;
            count     <= '0;
            compare   <= '0;
            count_tog <= 1'b0;
        end else begin
            count_tog <= ~count_tog;
            if (count_tog) begin
                count <= count + 32'd1;
            end

            cause[15:10] <= {int_i[5] | cause[30], int_i[4:0]};

            if (TIMER_IRQ_EN && (count == compare)) begin
                cause[30] <= 1'b1;
            end

            // Later assignments win, so an MTC0 to Count/Compare overrides the
            // increment and the timer set on the same edge.
            if (take_exc) begin
                if (!status[1]) begin
                    epc       <= delay_slot_i ? (pc_i - 32'd4) : pc_i;
                    cause[31] <= delay_slot_i;
                end
                cause[6:2] <= exc_code;
                status[1]  <= 1'b1;
                if (bad_from_pc) begin
                    badvaddr <= pc_i;
                end else if (bad_from_addr) begin
                    badvaddr <= bad_addr_i;
                end
            end else if (do_eret) begin
                status[1] <= 1'b0;
            end else if (do_mtc0) begin
                case (cp0_waddr)
                    REG_COUNT: begin
                        count     <= cp0_wdata;
                        count_tog <= 1'b0;
                    end
                    REG_COMPARE: begin
                        compare   <= cp0_wdata;
                        cause[30] <= 1'b0;
                    end
                    REG_STATUS: begin
                        status <= (status & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK)
                                  | STATUS_RESET;
                    end
                    REG_CAUSE: begin
                        cause[9:8] <= cp0_wdata[9:8];
                    end
                    REG_EPC: begin
                        epc <= cp0_wdata;
                    end
                    default: ;
                endcase
            end
        end
    end

    // MFC0 read port, no bypass of a same-cycle MTC0
    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            REG_BADVADDR: cp0_rdata = badvaddr;
            REG_COUNT:    cp0_rdata = count;
            REG_COMPARE:  cp0_rdata = compare;
            REG_STATUS:   cp0_rdata = status;
            REG_CAUSE:    cp0_rdata = cause;
            REG_EPC:      cp0_rdata = epc;
            default:      cp0_rdata = '0;
        endcase
    end

    // EPC forwarded from an in-flight MTC0 so an immediately following ERET returns correctly
    assign cp0_epc     = (cp0_we && (cp0_waddr == REG_EPC)) ? cp0_wdata : epc;
    assign timer_int_o = cause[30];

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed test of cp0_exception_unit: reset, timer, exception entry/return,
// priority, interrupts, stall and MTC0 forwarding/suppression.
module tb_cp0_exception_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [5:0]  int_i;
    logic [31:0] pc_i;
    logic        delay_slot_i;
    logic [7:0]  exc_flags_i;
    logic [31:0] bad_addr_i;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [3:0]  exception_type;
    logic [31:0] cp0_epc;
    logic        timer_int_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] rv;

    cp0_exception_unit #(.TIMER_IRQ_EN(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .int_i          (int_i),
        .pc_i           (pc_i),
        .delay_slot_i   (delay_slot_i),
        .exc_flags_i    (exc_flags_i),
        .bad_addr_i     (bad_addr_i),
        .cp0_we         (cp0_we),
        .cp0_waddr      (cp0_waddr),
        .cp0_wdata      (cp0_wdata),
        .cp0_raddr      (cp0_raddr),
        .cp0_rdata      (cp0_rdata),
        .exception_type (exception_type),
        .cp0_epc        (cp0_epc),
        .timer_int_o    (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_raddr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we    = 1'b1;
        cp0_waddr = a;
        cp0_wdata = d;
        step();
        cp0_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; int_i = '0; pc_i = '0; delay_slot_i = 1'b0;
        exc_flags_i = '0; bad_addr_i = '0; cp0_we = 1'b0; cp0_waddr = '0;
        cp0_wdata = '0; cp0_raddr = '0;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        rd(5'd12, rv); chk("rst_status", rv, 32'h0040_0000);
        rd(5'd9, rv);  chk("rst_count", rv, 32'd0);
        chk("rst_exc", {28'd0, exception_type}, 32'd0);
        chk("rst_ti", {31'd0, timer_int_o}, 32'd0);

        // Count runs at half rate; Count==Compare==0 right after reset sets TI
        repeat (6) step();
        rd(5'd9, rv); chk("count_6edges", rv, 32'd3);
        chk("ti_at_zero", {31'd0, timer_int_o}, 32'd1);

        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd5);
        chk("ti_clr_cmp", {31'd0, timer_int_o}, 32'd0);
        rd(5'd11, rv); chk("compare_rd", rv, 32'd5);
        repeat (9) step();
        rd(5'd9, rv); chk("count_5", rv, 32'd5);
        chk("ti_before", {31'd0, timer_int_o}, 32'd0);
        step();
        chk("ti_set", {31'd0, timer_int_o}, 32'd1);
        mtc0(5'd11, 32'hFFFF_FFFF);
        chk("ti_clr2", {31'd0, timer_int_o}, 32'd0);

        // SYS in a delay slot
        pc_i = 32'hBFC0_0100; delay_slot_i = 1'b1; exc_flags_i = 8'h08; #1;
        chk("sys_type", {28'd0, exception_type}, 32'd4);
        step();
        exc_flags_i = '0; delay_slot_i = 1'b0;
        rd(5'd14, rv); chk("sys_epc", rv, 32'hBFC0_00FC);
        rd(5'd13, rv); chk("sys_cause", rv, 32'h8000_0020);
        rd(5'd12, rv); chk("sys_status", rv, 32'h0040_0002);

        // Nested OV while EXL=1: EPC/BD hold, ExcCode updates
        pc_i = 32'h0000_1000; exc_flags_i = 8'h04; #1;
        chk("ov_type", {28'd0, exception_type}, 32'd7);
        step();
        exc_flags_i = '0;
        rd(5'd14, rv); chk("nest_epc", rv, 32'hBFC0_00FC);
        rd(5'd13, rv); chk("nest_cause", rv, 32'h8000_0030);

        exc_flags_i = 8'h20; #1;
        chk("eret_type", {28'd0, exception_type}, 32'd8);
        step();
        exc_flags_i = '0;
        rd(5'd12, rv); chk("eret_status", rv, 32'h0040_0000);

        // Priority between simultaneous flags
        exc_flags_i = 8'h06; #1; chk("prio_ri_ov", {28'd0, exception_type}, 32'd6);
        exc_flags_i = 8'hC0; #1; chk("prio_ld_st", {28'd0, exception_type}, 32'd2);
        exc_flags_i = 8'h80; #1; chk("prio_st", {28'd0, exception_type}, 32'd3);

        // Store AdES loads BadVAddr from bad_addr_i
        bad_addr_i = 32'h1234_5678; pc_i = 32'h0000_2000;
        step();
        exc_flags_i = '0;
        rd(5'd8, rv);  chk("ades_badv", rv, 32'h1234_5678);
        rd(5'd14, rv); chk("ades_epc", rv, 32'h0000_2000);
        rd(5'd13, rv); chk("ades_cause", rv, 32'h0000_0014);
        exc_flags_i = 8'h20;
        step();
        exc_flags_i = '0;

        // External interrupt on IP2
        int_i = 6'd1;
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, rv); chk("int_status", rv, 32'h0040_0401);
        chk("int_type", {28'd0, exception_type}, 32'd1);
        pc_i = 32'd0; #1;
        chk("int_bubble", {28'd0, exception_type}, 32'd0);
        pc_i = 32'h0000_3000; stall = 1'b1; exc_flags_i = 8'hFF; #1;
        chk("stall_type", {28'd0, exception_type}, 32'd0);
        step();
        stall = 1'b0; exc_flags_i = '0;
        rd(5'd12, rv); chk("stall_status", rv, 32'h0040_0401);
        rd(5'd14, rv); chk("stall_epc", rv, 32'h0000_2000);

        // INT taken with a same-cycle MTC0 Cause that must be suppressed
        cp0_we = 1'b1; cp0_waddr = 5'd13; cp0_wdata = 32'h0000_0300; #1;
        chk("int_type2", {28'd0, exception_type}, 32'd1);
        step();
        cp0_we = 1'b0;
        rd(5'd14, rv); chk("int_epc", rv, 32'h0000_3000);
        rd(5'd13, rv); chk("int_cause", rv, 32'h0000_0400);
        rd(5'd12, rv); chk("int_exl", rv, 32'h0040_0403);

        int_i = '0; exc_flags_i = 8'h20; #1;
        chk("eret2_type", {28'd0, exception_type}, 32'd8);
        step();

        // MTC0 EPC forwarded to cp0_epc alongside ERET, but not committed
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h8000_0040; #1;
        chk("epc_fwd", cp0_epc, 32'h8000_0040);
        chk("epc_fwd_type", {28'd0, exception_type}, 32'd8);
        cp0_we = 1'b0; #1;
        chk("epc_nofwd", cp0_epc, 32'h0000_3000);
        cp0_we = 1'b1;
        step();
        cp0_we = 1'b0; exc_flags_i = '0;
        rd(5'd14, rv); chk("epc_suppr", rv, 32'h0000_3000);
        rd(5'd12, rv); chk("eret2_status", rv, 32'h0040_0401);

        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, rv); chk("cause_wmask", rv, 32'h0000_0300);
        rd(5'd0, rv);  chk("rd_unmapped", rv, 32'd0);

        // Asynchronous reset between edges
        @(posedge clk);
        #3 rst = 1'b1;
        rd(5'd12, rv); chk("arst_status", rv, 32'h0040_0000);
        rd(5'd9, rv);  chk("arst_count", rv, 32'd0);
        chk("arst_exc", {28'd0, exception_type}, 32'd0);
        chk("arst_ti", {31'd0, timer_int_o}, 32'd0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
